// File: rtl/imem_loader.sv
// Instruction-memory loader: assembles a big-endian byte stream into 32-bit words and writes each byte to IMEM.
// Optional running XOR checksum of loaded words is enabled with `define IMEM_LOADER_CHECKSUM_EN.
module imem_loader #(
  parameter int MEM_BYTES = 1024
) (
  input  logic        CLK,
  input  logic        Reset,
  input  logic        Start,
  input  logic [31:0] BaseAddr,
  input  logic [8:0]  WordCnt,
  input  logic [7:0]  ByteIn,
  input  logic        ByteValid,
  output logic        ByteReady,
  output logic        MemWE,
  output logic [31:0] MemAddr,
  output logic [7:0]  MemData,
  output logic [31:0] WordOut,
  output logic        WordValid,
  output logic        Busy,
  output logic        Done,
  output logic        Err,
  output logic [31:0] Checksum,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t      state, state_nx;
  logic [31:0] addr;
  logic [10:0] remaining;
  logic [1:0]  byte_idx;
  logic [23:0] partial;

  logic [32:0] end_addr;
  logic        req_bad;
  logic        start_ok;
  logic        accept;
  logic        last_byte;
  logic        word_end;

  // Byte handshake: a byte transfers on a rising edge where ByteValid and
  // ByteReady are both high; ByteReady is high exactly while in LOAD, and a
  // low ByteValid in LOAD simply stalls the transfer.
  assign ByteReady = (state == ST_LOAD);
  assign Busy      = (state == ST_LOAD);
  assign dbg_state = state;

  // End address at 33 bits so a request near the top of the 32-bit space cannot wrap.
  assign end_addr  = {1'b0, BaseAddr} + {22'd0, WordCnt, 2'b00};
  assign req_bad   = (BaseAddr[1:0] != 2'b00) || (end_addr > 33'(MEM_BYTES));
  assign start_ok  = (state == ST_IDLE) && Start && !req_bad;
  assign accept    = (state == ST_LOAD) && ByteValid;
  assign last_byte = accept && (remaining == 11'd1);
  assign word_end  = accept && (byte_idx == 2'd3);

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: begin
        if (start_ok) begin
          state_nx = (WordCnt == 9'd0) ? ST_DONE : ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (last_byte) begin
          state_nx = ST_DONE;
        end
      end
      ST_DONE: state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      addr      <= 32'd0;
      remaining <= 11'd0;
      byte_idx  <= 2'd0;
      partial   <= 24'd0;
      MemWE     <= 1'b0;
      MemAddr   <= 32'd0;
      MemData   <= 8'd0;
      WordOut   <= 32'd0;
      WordValid <= 1'b0;
      Done      <= 1'b0;
      Err       <= 1'b0;
    end else begin
      MemWE     <= accept;
      WordValid <= 1'b0;
      Done      <= (state == ST_DONE);
      if ((state == ST_IDLE) && Start) begin
        Err <= req_bad;
      end
      if (start_ok) begin
        addr      <= BaseAddr;
        remaining <= {WordCnt, 2'b00};
        byte_idx  <= 2'd0;
      end
      if (accept) begin
        MemAddr   <= addr;
        MemData   <= ByteIn;
        addr      <= addr + 32'd1;
        remaining <= remaining - 11'd1;
        byte_idx  <= byte_idx + 2'd1;
        if (word_end) begin
          WordOut   <= {partial, ByteIn};
          WordValid <= 1'b1;
        end else begin
          partial <= {partial[15:0], ByteIn};
        end
      end
    end
  end

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [31:0] csum_q;

  // Updates on the same edge that publishes the word, so it already includes WordOut while WordValid is high.
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      csum_q <= 32'd0;
    end else if (start_ok) begin
      csum_q <= 32'd0;
    end else if (word_end) begin
      csum_q <= csum_q ^ {partial, ByteIn};
    end
  end

  assign Checksum = csum_q;
`else
  assign Checksum = 32'd0;
`endif

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: write-stream and word scoreboards, Done timing,
// request errors, stalls and mid-load reset.
module tb_imem_loader;

  logic        CLK = 1'b0;
  logic        Reset;
  logic        Start;
  logic [31:0] BaseAddr;
  logic [8:0]  WordCnt;
  logic [7:0]  ByteIn;
  logic        ByteValid;
  logic        ByteReady;
  logic        MemWE;
  logic [31:0] MemAddr;
  logic [7:0]  MemData;
  logic [31:0] WordOut;
  logic        WordValid;
  logic        Busy;
  logic        Done;
  logic        Err;
  logic [31:0] Checksum;
  logic [1:0]  dbg_state;

`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam bit CSUM_EN = 1'b1;
`else
  localparam bit CSUM_EN = 1'b0;
`endif

  imem_loader #(.MEM_BYTES(1024)) dut (
    .CLK       (CLK),
    .Reset     (Reset),
    .Start     (Start),
    .BaseAddr  (BaseAddr),
    .WordCnt   (WordCnt),
    .ByteIn    (ByteIn),
    .ByteValid (ByteValid),
    .ByteReady (ByteReady),
    .MemWE     (MemWE),
    .MemAddr   (MemAddr),
    .MemData   (MemData),
    .WordOut   (WordOut),
    .WordValid (WordValid),
    .Busy      (Busy),
    .Done      (Done),
    .Err       (Err),
    .Checksum  (Checksum),
    .dbg_state (dbg_state)
  );

  // clock / reset
  always #5 CLK = ~CLK;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int done_cnt = 0;
  int done_cyc = -1;
  int last_we_cyc = -1;

  logic [39:0] wr_q[$];
  logic [39:0] exp_q[$];
  logic [31:0] word_q[$];
  logic [31:0] exp_word_q[$];

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // monitor: capture every memory write, word and Done pulse
  always @(negedge CLK) begin
    if (MemWE) begin
      wr_q.push_back({MemAddr, MemData});
      last_we_cyc = cyc;
    end
    if (WordValid) begin
      word_q.push_back(WordOut);
      check("wv_with_we", {63'd0, MemWE}, 64'd1);
    end
    if (Done) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  // driver tasks
  task automatic clear_logs();
    wr_q.delete();
    exp_q.delete();
    word_q.delete();
    exp_word_q.delete();
    done_cnt = 0;
  endtask

  task automatic start_load(input logic [31:0] base, input logic [8:0] cnt);
    @(negedge CLK);
    Start = 1'b1;
    BaseAddr = base;
    WordCnt = cnt;
    @(negedge CLK);
    Start = 1'b0;
  endtask

  // In toggle mode every idle cycle also drives a misaligned Start, which must be ignored.
  task automatic send_byte(input logic [7:0] b, input bit toggle);
    ByteValid = 1'b1;
    ByteIn = b;
    @(negedge CLK);
    if (toggle) begin
      ByteValid = 1'b0;
      ByteIn = 8'h00;
      Start = 1'b1;
      BaseAddr = 32'h3;
      WordCnt = 9'd1;
      @(negedge CLK);
      Start = 1'b0;
    end
  endtask

  task automatic send_word(input logic [31:0] w, input bit toggle);
    for (int k = 0; k < 4; k++) begin
      send_byte(w[31-8*k -: 8], toggle);
    end
  endtask

  task automatic expect_word(input logic [31:0] base, input logic [31:0] w);
    for (int k = 0; k < 4; k++) begin
      exp_q.push_back({base + 32'(k), w[31-8*k -: 8]});
    end
    exp_word_q.push_back(w);
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (done_cnt == 0 && n < 20) begin
      @(negedge CLK);
      n++;
    end
    check({tag, "_done"}, 64'(done_cnt), 64'd1);
    repeat (2) @(negedge CLK);
    check({tag, "_done_once"}, 64'(done_cnt), 64'd1);
  endtask

  task automatic compare_logs(input string tag);
    check({tag, "_wr_cnt"}, 64'(wr_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < wr_q.size() && i < exp_q.size(); i++) begin
      check({tag, "_wr"}, 64'(wr_q[i]), 64'(exp_q[i]));
    end
    check({tag, "_word_cnt"}, 64'(word_q.size()), 64'(exp_word_q.size()));
    for (int i = 0; i < word_q.size() && i < exp_word_q.size(); i++) begin
      check({tag, "_word"}, 64'(word_q[i]), 64'(exp_word_q[i]));
    end
  endtask

  initial begin
    Reset = 1'b1;
    Start = 1'b0;
    BaseAddr = 32'd0;
    WordCnt = 9'd0;
    ByteIn = 8'd0;
    ByteValid = 1'b0;
    repeat (2) @(negedge CLK);
    check("rst_ctrl", {58'd0, MemWE, WordValid, Busy, Done, Err, ByteReady}, 64'd0);
    check("rst_word", 64'(WordOut), 64'd0);
    check("rst_csum", 64'(Checksum), 64'd0);
    check("rst_state", 64'(dbg_state), 64'd0);
    Reset = 1'b0;

    // two-word load from address 0
    clear_logs();
    start_load(32'h0, 9'd2);
    check("t1_busy", {63'd0, Busy}, 64'd1);
    check("t1_ready", {63'd0, ByteReady}, 64'd1);
    send_word(32'h20080005, 1'b0);
    send_word(32'hAC010004, 1'b0);
    ByteValid = 1'b0;
    expect_word(32'h0, 32'h20080005);
    expect_word(32'h4, 32'hAC010004);
    wait_done("t1");
    check("t1_done_lat", 64'(done_cyc - last_we_cyc), 64'd1);
    compare_logs("t1");
    check("t1_wordout", 64'(WordOut), 64'hAC010004);
    check("t1_busy_end", {63'd0, Busy}, 64'd0);
    check("t1_csum", 64'(Checksum), CSUM_EN ? 64'h8C090001 : 64'd0);

    // out-of-range request, then an exactly-fitting one clears Err
    clear_logs();
    start_load(32'h3FC, 9'd2);
    check("t2_err", {63'd0, Err}, 64'd1);
    check("t2_busy", {63'd0, Busy}, 64'd0);
    repeat (3) @(negedge CLK);
    check("t2_no_wr", 64'(wr_q.size()), 64'd0);
    start_load(32'h3FC, 9'd1);
    check("t2_err_clr", {63'd0, Err}, 64'd0);
    check("t2_busy_ok", {63'd0, Busy}, 64'd1);
    send_word(32'h12345678, 1'b0);
    ByteValid = 1'b0;
    expect_word(32'h3FC, 32'h12345678);
    wait_done("t2");
    compare_logs("t2");

    // misaligned base, then zero-word load
    clear_logs();
    start_load(32'h2, 9'd1);
    check("t3_err", {63'd0, Err}, 64'd1);
    check("t3_state", 64'(dbg_state), 64'd0);
    start_load(32'h0, 9'd0);
    check("t3_err_clr", {63'd0, Err}, 64'd0);
    check("t3_busy", {63'd0, Busy}, 64'd0);
    wait_done("t3");
    compare_logs("t3");

    // stalled load with ByteValid toggling and Start pulses ignored
    clear_logs();
    start_load(32'h20, 9'd1);
    send_word(32'hDEADBEEF, 1'b1);
    ByteValid = 1'b0;
    expect_word(32'h20, 32'hDEADBEEF);
    wait_done("t4");
    compare_logs("t4");
    check("t4_err", {63'd0, Err}, 64'd0);

    // reset after two bytes of a word
    clear_logs();
    start_load(32'h40, 9'd1);
    send_byte(8'hA1, 1'b0);
    send_byte(8'hB2, 1'b0);
    ByteIn = 8'hC3;
    #2 Reset = 1'b1;
    #1;
    check("t5_ctrl", {58'd0, MemWE, WordValid, Busy, Done, Err, ByteReady}, 64'd0);
    check("t5_addr", 64'(MemAddr), 64'd0);
    check("t5_data", 64'(MemData), 64'd0);
    check("t5_word", 64'(WordOut), 64'd0);
    check("t5_csum", 64'(Checksum), 64'd0);
    repeat (3) @(negedge CLK);
    Reset = 1'b0;
    repeat (2) @(negedge CLK);
    ByteValid = 1'b0;
    exp_q.push_back({32'h40, 8'hA1});
    exp_q.push_back({32'h41, 8'hB2});
    compare_logs("t5");
    clear_logs();
    start_load(32'h80, 9'd1);
    send_word(32'h01020304, 1'b0);
    ByteValid = 1'b0;
    expect_word(32'h80, 32'h01020304);
    wait_done("t5b");
    compare_logs("t5b");

    // checksum over two words
    clear_logs();
    start_load(32'h10, 9'd2);
    send_word(32'h12345678, 1'b0);
    send_word(32'h0F0F0F0F, 1'b0);
    ByteValid = 1'b0;
    expect_word(32'h10, 32'h12345678);
    expect_word(32'h14, 32'h0F0F0F0F);
    wait_done("t6");
    compare_logs("t6");
    check("t6_csum", 64'(Checksum), CSUM_EN ? 64'h1D3B5977 : 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 SHALL have parameter MEM_BYTES, default 1024, giving the byte capacity of the target instruction memory.
REQ-002 SHALL have port CLK, input, 1 bit: single clock; all state changes on its rising edge.
REQ-003 SHALL have port Reset, input, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL have port Start, input, 1 bit: load request, sampled in IDLE only.
REQ-005 SHALL have port BaseAddr, input, 32 bits: byte start address, latched on accepted Start.
REQ-006 SHALL have port WordCnt, input, 9 bits: number of 32-bit words to load, latched on accepted Start.
REQ-007 SHALL have port ByteIn, input, 8 bits: incoming program byte.
REQ-008 SHALL have port ByteValid, input, 1 bit: ByteIn is valid.
REQ-009 SHALL have port ByteReady, output, 1 bit: loader accepts a byte this cycle.
REQ-010 SHALL have port MemWE, output, 1 bit: byte write strobe to instruction memory.
REQ-011 SHALL have port MemAddr, output, 32 bits: byte write address.
REQ-012 SHALL have port MemData, output, 8 bits: byte write data.
REQ-013 SHALL have port WordOut, output, 32 bits: last assembled word, big-endian.
REQ-014 SHALL have port WordValid, output, 1 bit: one-cycle pulse when WordOut updates.
REQ-015 SHALL have port Busy, output, 1 bit: high in LOAD.
REQ-016 SHALL have port Done, output, 1 bit: one-cycle completion pulse.
REQ-017 SHALL have port Err, output, 1 bit: sticky request error flag.
REQ-018 SHALL have port Checksum, output, 32 bits: running XOR of loaded words (see Configuration).

Function
REQ-019 SHALL implement states IDLE, LOAD and DONE; DONE lasts exactly one cycle, then returns to IDLE.
REQ-020 In IDLE, Start=1 SHALL clear Err and be rejected, setting Err=1 and staying in IDLE, when BaseAddr[1:0]!=0 or BaseAddr+4*WordCnt > MEM_BYTES, computed at 33-bit width without wrap.
REQ-021 In IDLE, an accepted Start with WordCnt=0 SHALL go directly to DONE; with WordCnt>0 it SHALL go to LOAD, latch the address and set the remaining count to 4*WordCnt bytes.
REQ-022 ByteReady SHALL equal (state==LOAD), combinationally; a byte is accepted when ByteValid and ByteReady are both high.
REQ-023 Each accepted byte SHALL produce, on the next cycle, MemWE=1, MemAddr=current address and MemData=ByteIn; the address then increments by 1; MemWE SHALL be 0 otherwise.
REQ-024 Byte k (0..3) of each word SHALL map to address base+4n+k and to WordOut bits [31-8k:24-8k], so the first byte is the most significant byte (big-endian).
REQ-025 On the 4th byte of a word, WordOut SHALL update and WordValid SHALL pulse in the same cycle as that byte's MemWE.
REQ-026 Acceptance of the last byte SHALL move to DONE; Done=1 in the cycle after the final MemWE pulse.
REQ-027 Start SHALL be ignored in LOAD and DONE; ByteValid with no handshake in progress SHALL be ignored outside LOAD.
REQ-028 ByteValid low in LOAD SHALL stall with no state, address or count change.

Reset
REQ-029 Reset SHALL asynchronously force state IDLE and set all outputs to 0, including WordOut, Checksum and Err.
REQ-030 Reset in LOAD SHALL discard the partial word; bytes already written SHALL remain untouched, and no MemWE SHALL be issued after Reset asserts.

Configuration
REQ-031 With IMEM_LOADER_CHECKSUM_EN defined, Checksum SHALL clear on accepted Start and become Checksum XOR WordOut on each WordValid edge.
REQ-032 Without IMEM_LOADER_CHECKSUM_EN, Checksum SHALL be constant 0 and no checksum register SHALL exist.

Verification
REQ-033 Start, BaseAddr=0, WordCnt=2, bytes 20 08 00 05 AC 01 00 04 -> writes to addresses 0..7 in order; WordOut=0x20080005 then 0xAC010004; Done one cycle after the 8th MemWE.
REQ-034 BaseAddr=0x3FC, WordCnt=2 -> Err=1, Busy stays 0, no MemWE; a following valid Start clears Err.
REQ-035 BaseAddr=2 -> Err=1; WordCnt=0 with BaseAddr=0 -> Done pulse in the next cycle and no writes.
REQ-036 ByteValid toggled 1/0 every cycle during a 1-word load -> exactly 4 MemWE pulses at consecutive addresses, with correct data.
REQ-037 Reset asserted after 2 bytes of a word -> all outputs 0 immediately and no further MemWE; a new Start then loads correctly.
REQ-038 With the macro defined, loading 0x12345678 and 0x0F0F0F0F -> Checksum=0x1D3B5977; without the macro -> Checksum=0.
